// File: rtl/cam_pkg.sv
// Shared types and defaults for the camera frame-control slice.
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    ACTIVE   = 2'd2
  } state_t;

  localparam logic [1:0] MODE_RAW  = 2'd0;
  localparam logic [1:0] MODE_GREY = 2'd1;

  localparam int H_ACTIVE_DEF = 1280;
  localparam int V_ACTIVE_DEF = 960;
  localparam int COORD_W      = 11;

endpackage

// File: rtl/sync_edge_det.sv
// Registers a single-bit strobe once and reports its rising and falling edges.
module sync_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_q;

  // previous-cycle copy of the input
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= 1'b0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_rise = i_d & ~r_q;
  assign o_fall = ~i_d & r_q;

endmodule

// File: rtl/bayer_frame_ctrl.sv
// Frame sequencer: gates sensor strobes into pixel valid, tracks X/Y, and
// applies run/stop and mode changes only on frame boundaries.
module bayer_frame_ctrl
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int MODE_W   = 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iFVAL,
  input  logic              iLVAL,
  input  logic              iSTART,
  input  logic              iSTOP,
  input  logic [MODE_W-1:0] iMODE_REQ,
  input  logic              iMODE_STB,
  output logic [10:0]       oX_Cont,
  output logic [10:0]       oY_Cont,
  output logic              oDVAL,
  output logic              oLB_CLKEN,
  output logic [MODE_W-1:0] oMODE,
  output logic [31:0]       oFRAME_CNT,
  output logic              oBUSY,
  output logic              oERR
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_ACTIVE - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic                w_sof;
  logic                w_frame_end;
  logic                w_fval_rise;
  logic                w_fval_fall;
  logic                w_lval_rise;
  logic                w_lval_fall;
  logic                w_pix;

  logic [COORD_W-1:0]  r_x;
  logic [COORD_W-1:0]  r_y;
  logic                r_x_full;
  logic                r_y_full;
  logic                r_line_px;
  logic [COORD_W-1:0]  r_x_out;
  logic [COORD_W-1:0]  r_y_out;
  logic                r_dval;
  logic [MODE_W-1:0]   r_mode;
  logic [MODE_W-1:0]   r_pend_mode;
  logic                r_pend_vld;
  logic                r_stop_req;
  logic [31:0]         r_frame_cnt;
  logic                r_err;

  sync_edge_det u_fval_edge (
    .i_clk   (iCLK),
    .i_rst_n (iRST),
    .i_d     (iFVAL),
    .o_rise  (w_fval_rise),
    .o_fall  (w_fval_fall)
  );

  sync_edge_det u_lval_edge (
    .i_clk   (iCLK),
    .i_rst_n (iRST),
    .i_d     (iLVAL),
    .o_rise  (w_lval_rise),
    .o_fall  (w_lval_fall)
  );

  assign w_pix = iFVAL & iLVAL;

  // state register
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // next state plus frame-boundary strobes; iSTOP beats iSTART and SOF
  always_comb begin
    w_next_state = r_state;
    w_sof        = 1'b0;
    w_frame_end  = 1'b0;
    case (r_state)
      IDLE: begin
        if (iSTART && !iSTOP) begin
          w_next_state = WAIT_SOF;
        end else begin
          w_next_state = IDLE;
        end
      end
      WAIT_SOF: begin
        if (iSTOP) begin
          w_next_state = IDLE;
        end else if (w_fval_rise) begin
          w_next_state = ACTIVE;
          w_sof        = 1'b1;
        end else begin
          w_next_state = WAIT_SOF;
        end
      end
      ACTIVE: begin
        if (w_fval_fall) begin
          w_frame_end  = 1'b1;
          w_next_state = (r_stop_req || iSTOP) ? IDLE : WAIT_SOF;
        end else begin
          w_next_state = ACTIVE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // frame bookkeeping: count, stop request, pending and applied mode
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_frame_cnt <= 32'd0;
      r_stop_req  <= 1'b0;
      r_mode      <= MODE_W'(MODE_RAW);
      r_pend_mode <= MODE_W'(MODE_RAW);
      r_pend_vld  <= 1'b0;
    end else begin
      if (w_frame_end) r_frame_cnt <= r_frame_cnt + 32'd1;
      if (w_sof) begin
        r_stop_req <= 1'b0;
      end else if ((r_state == ACTIVE) && iSTOP) begin
        r_stop_req <= 1'b1;
      end
      // a strobe on the SOF cycle stays pending for the following frame
      if (w_sof) begin
        if (r_pend_vld) r_mode <= r_pend_mode;
        r_pend_vld <= iMODE_STB;
      end else if (iMODE_STB) begin
        r_pend_vld <= 1'b1;
      end
      if (iMODE_STB) r_pend_mode <= iMODE_REQ;
    end
  end

  // pixel qualification and saturating X/Y coordinates
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_dval    <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_x_full  <= 1'b0;
      r_y_full  <= 1'b0;
      r_line_px <= 1'b0;
      r_x_out   <= '0;
      r_y_out   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_dval <= w_pix & (r_state == ACTIVE);
      if (w_sof) begin
        r_x       <= '0;
        r_y       <= '0;
        r_x_full  <= 1'b0;
        r_y_full  <= 1'b0;
        r_line_px <= 1'b0;
      end else if (r_state == ACTIVE) begin
        if (w_pix) begin
          r_x_out   <= r_x;
          r_y_out   <= r_y;
          r_line_px <= 1'b1;
          if (r_x_full || r_y_full) r_err <= 1'b1;
          if (r_x == X_MAX) begin
            r_x_full <= 1'b1;
          end else begin
            r_x <= r_x + 11'd1;
          end
        end else if (w_lval_fall) begin
          r_x      <= '0;
          r_x_full <= 1'b0;
          if (r_line_px) begin
            if (r_y == Y_MAX) begin
              r_y_full <= 1'b1;
            end else begin
              r_y <= r_y + 11'd1;
            end
          end
        end else if (w_lval_rise) begin
          r_line_px <= 1'b0;
        end
      end
    end
  end

  assign oX_Cont    = r_x_out;
  assign oY_Cont    = r_y_out;
  assign oDVAL      = r_dval;
  assign oLB_CLKEN  = r_dval;
  assign oMODE      = r_mode;
  assign oFRAME_CNT = r_frame_cnt;
  assign oBUSY      = (r_state != IDLE);
  assign oERR       = r_err;

endmodule

// File: tb/tb_bayer_frame_ctrl.sv
// Scoreboard bench for bayer_frame_ctrl on a 4x3 geometry.
module tb_bayer_frame_ctrl;

  localparam int H = 4;
  localparam int V = 3;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [1:0]  m;
  } exp_t;

  logic        iCLK = 1'b0;
  logic        iRST, iFVAL, iLVAL, iSTART, iSTOP, iMODE_STB;
  logic [1:0]  iMODE_REQ;
  logic [10:0] oX_Cont, oY_Cont;
  logic        oDVAL, oLB_CLKEN, oBUSY, oERR;
  logic [1:0]  oMODE;
  logic [31:0] oFRAME_CNT;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  bayer_frame_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .MODE_W(2)) dut (
    .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iLVAL(iLVAL),
    .iSTART(iSTART), .iSTOP(iSTOP), .iMODE_REQ(iMODE_REQ), .iMODE_STB(iMODE_STB),
    .oX_Cont(oX_Cont), .oY_Cont(oY_Cont), .oDVAL(oDVAL), .oLB_CLKEN(oLB_CLKEN),
    .oMODE(oMODE), .oFRAME_CNT(oFRAME_CNT), .oBUSY(oBUSY), .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // advance one cycle, then consume any pixel the DUT flagged
  task automatic tick();
    exp_t e;
    @(posedge iCLK);
    #1;
    if (oDVAL) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_dval: got x=%0d y=%0d with nothing expected", oX_Cont, oY_Cont);
      end else begin
        e = sb.pop_front();
        if ({oX_Cont, oY_Cont, oMODE, oLB_CLKEN} !== {e.x, e.y, e.m, 1'b1}) begin
          bad++;
          $display("FAIL pixel: got x=%0d y=%0d mode=%0d lb=%0b, want x=%0d y=%0d mode=%0d lb=1",
                   oX_Cont, oY_Cont, oMODE, oLB_CLKEN, e.x, e.y, e.m);
        end
      end
    end
  endtask

  task automatic drive_frame(input int lines, input int ppl, input bit cap, input logic [1:0] m,
                             input bit stb_rise, input bit stb_mid, input logic [1:0] req,
                             input bit stop_mid);
    exp_t e;
    iFVAL = 1'b1;
    if (stb_rise) begin
      iMODE_STB = 1'b1;
      iMODE_REQ = req;
    end
    tick();
    iMODE_STB = 1'b0;
    tick();
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < ppl; p++) begin
        iLVAL = 1'b1;
        if (cap) begin
          e.x = 11'((p > H - 1) ? H - 1 : p);
          e.y = 11'((l > V - 1) ? V - 1 : l);
          e.m = m;
          sb.push_back(e);
        end
        tick();
      end
      iLVAL = 1'b0;
      if (l == 0 && stb_mid) begin
        iMODE_STB = 1'b1;
        iMODE_REQ = req;
      end
      if (l == 0 && stop_mid) iSTOP = 1'b1;
      tick();
      iMODE_STB = 1'b0;
      iSTOP     = 1'b0;
      tick();
    end
    iFVAL = 1'b0;
    tick();
    tick();
    tick();
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL missing_dval: %0d expected pixels never appeared", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    iRST = 1'b0; iFVAL = 1'b0; iLVAL = 1'b0; iSTART = 1'b0; iSTOP = 1'b0;
    iMODE_STB = 1'b0; iMODE_REQ = 2'd0;
    tick(); tick();
    total++; if (oDVAL !== 1'b0) begin bad++; $display("FAIL rst_dval: got %0b want 0", oDVAL); end
    total++; if (oLB_CLKEN !== 1'b0) begin bad++; $display("FAIL rst_lb: got %0b want 0", oLB_CLKEN); end
    total++; if (oX_Cont !== 11'd0) begin bad++; $display("FAIL rst_x: got %0d want 0", oX_Cont); end
    total++; if (oY_Cont !== 11'd0) begin bad++; $display("FAIL rst_y: got %0d want 0", oY_Cont); end
    total++; if (oMODE !== 2'd0) begin bad++; $display("FAIL rst_mode: got %0d want 0", oMODE); end
    total++; if (oFRAME_CNT !== 32'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", oFRAME_CNT); end
    total++; if (oBUSY !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", oBUSY); end
    total++; if (oERR !== 1'b0) begin bad++; $display("FAIL rst_err: got %0b want 0", oERR); end
    iRST = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    iSTART = 1'b1; tick(); iSTART = 1'b0;
    total++; if (oBUSY !== 1'b1) begin bad++; $display("FAIL start_busy: got %0b want 1", oBUSY); end
    drive_frame(3, 4, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    total++; if (oFRAME_CNT !== 32'd1) begin bad++; $display("FAIL basic_cnt: got %0d want 1", oFRAME_CNT); end
    total++; if (oERR !== 1'b0) begin bad++; $display("FAIL basic_err: got %0b want 0", oERR); end
    total++; if (oBUSY !== 1'b1) begin bad++; $display("FAIL basic_busy: got %0b want 1", oBUSY); end
  endtask

  task automatic test_skip();
    iSTOP = 1'b1; tick(); iSTOP = 1'b0; tick();
    total++; if (oBUSY !== 1'b0) begin bad++; $display("FAIL waitsof_stop: got busy=%0b want 0", oBUSY); end
    iFVAL = 1'b1; tick(); tick();
    iLVAL = 1'b1; tick(); tick();
    iLVAL = 1'b0; iSTART = 1'b1; tick(); iSTART = 1'b0;
    iLVAL = 1'b1; tick(); tick();
    iLVAL = 1'b0; tick();
    iFVAL = 1'b0; tick(); tick();
    total++; if (oFRAME_CNT !== 32'd1) begin bad++; $display("FAIL skip_cnt: got %0d want 1", oFRAME_CNT); end
    drive_frame(3, 4, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    total++; if (oFRAME_CNT !== 32'd2) begin bad++; $display("FAIL skip_next_cnt: got %0d want 2", oFRAME_CNT); end
  endtask

  task automatic test_mode();
    drive_frame(3, 4, 1'b1, 2'd0, 1'b0, 1'b1, 2'd1, 1'b0);
    total++; if (oMODE !== 2'd0) begin bad++; $display("FAIL mode_deferred: got %0d want 0", oMODE); end
    drive_frame(3, 4, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0);
    drive_frame(3, 4, 1'b1, 2'd1, 1'b1, 1'b0, 2'd2, 1'b0);
    total++; if (oMODE !== 2'd1) begin bad++; $display("FAIL mode_sof_stb: got %0d want 1", oMODE); end
    drive_frame(3, 4, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0);
    iMODE_STB = 1'b1; iMODE_REQ = 2'd3; tick();
    iMODE_REQ = 2'd0; tick();
    iMODE_STB = 1'b0; tick();
    drive_frame(3, 4, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    total++; if (oFRAME_CNT !== 32'd7) begin bad++; $display("FAIL mode_cnt: got %0d want 7", oFRAME_CNT); end
  endtask

  task automatic test_stop();
    drive_frame(3, 4, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1);
    total++; if (oFRAME_CNT !== 32'd8) begin bad++; $display("FAIL stop_cnt: got %0d want 8", oFRAME_CNT); end
    total++; if (oBUSY !== 1'b0) begin bad++; $display("FAIL stop_busy: got %0b want 0", oBUSY); end
    drive_frame(3, 4, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    total++; if (oFRAME_CNT !== 32'd8) begin bad++; $display("FAIL idle_cnt: got %0d want 8", oFRAME_CNT); end
    iSTART = 1'b1; iSTOP = 1'b1; tick(); iSTART = 1'b0; iSTOP = 1'b0; tick();
    total++; if (oBUSY !== 1'b0) begin bad++; $display("FAIL start_stop: got busy=%0b want 0", oBUSY); end
  endtask

  task automatic test_overflow();
    iSTART = 1'b1; tick(); iSTART = 1'b0;
    drive_frame(1, 5, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    total++; if (oERR !== 1'b1) begin bad++; $display("FAIL ovf_err: got %0b want 1", oERR); end
    drive_frame(3, 4, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    total++; if (oERR !== 1'b1) begin bad++; $display("FAIL err_sticky: got %0b want 1", oERR); end
    total++; if (oFRAME_CNT !== 32'd10) begin bad++; $display("FAIL ovf_cnt: got %0d want 10", oFRAME_CNT); end
  endtask

  task automatic test_midreset();
    exp_t e;
    iFVAL = 1'b1; tick(); tick();
    for (int p = 0; p < 2; p++) begin
      iLVAL = 1'b1;
      e.x = 11'(p); e.y = 11'd0; e.m = 2'd0;
      sb.push_back(e);
      tick();
    end
    #2 iRST = 1'b0;
    #1;
    total++; if (oDVAL !== 1'b0) begin bad++; $display("FAIL mrst_dval: got %0b want 0", oDVAL); end
    total++; if (oX_Cont !== 11'd0) begin bad++; $display("FAIL mrst_x: got %0d want 0", oX_Cont); end
    total++; if (oFRAME_CNT !== 32'd0) begin bad++; $display("FAIL mrst_cnt: got %0d want 0", oFRAME_CNT); end
    total++; if (oBUSY !== 1'b0) begin bad++; $display("FAIL mrst_busy: got %0b want 0", oBUSY); end
    total++; if (oERR !== 1'b0) begin bad++; $display("FAIL mrst_err: got %0b want 0", oERR); end
    sb.delete();
    tick();
    iRST = 1'b1;
    tick(); tick();
    iLVAL = 1'b0; tick();
    iFVAL = 1'b0; tick(); tick();
    drive_frame(3, 4, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    total++; if (oFRAME_CNT !== 32'd0) begin bad++; $display("FAIL mrst_idle_cnt: got %0d want 0", oFRAME_CNT); end
    iSTART = 1'b1; tick(); iSTART = 1'b0;
    drive_frame(3, 4, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    total++; if (oFRAME_CNT !== 32'd1) begin bad++; $display("FAIL mrst_restart_cnt: got %0d want 1", oFRAME_CNT); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skip();
    test_mode();
    test_stop();
    test_overflow();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
